// File: rtl/sum_diff_decoder.sv
// sum_diff_decoder: recovers (A, B, A>B) from a two-beat S=A+B / D=A-B stream.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   IN_VALID/IN_READY   input beat handshake; IN_FIRST marks the sum beat
//   IN_DATA             NBITS+1 encoded word (S, then D)
//   OUT_VALID/OUT_READY recovered pair handshake
//   A_OUT, B_OUT, GT_OUT recovered operands and A>B flag
//   ERR                 one-cycle pulse on protocol or parity error
module sum_diff_decoder #(
  parameter int NBITS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             IN_FIRST,
  input  logic [NBITS:0]   IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [NBITS-1:0] A_OUT,
  output logic [NBITS-1:0] B_OUT,
  output logic             GT_OUT,
  output logic             ERR
);
  typedef enum logic [1:0] {IDLE, WAIT_DIFF, HOLD} state_t;
  state_t             state_q;
  logic [NBITS:0]     s_q;
  logic [NBITS-1:0]   a_q, b_q, a_d, b_d;
  logic               gt_q, gt_d, err_q, in_fire;
  logic [NBITS+1:0]   s_ext, d_ext;
  // S is unsigned and D two's complement; one extra bit absorbs the carry of S+D.
  always_comb begin
    s_ext   = {1'b0, s_q};
    d_ext   = {IN_DATA[NBITS], IN_DATA};
    a_d     = NBITS'((s_ext + d_ext) >> 1);
    b_d     = NBITS'((s_ext - d_ext) >> 1);
    gt_d    = !IN_DATA[NBITS] && |IN_DATA;
    in_fire = IN_VALID && IN_READY;
  end
  assign IN_READY  = (state_q != HOLD) || OUT_READY;
  assign OUT_VALID = (state_q == HOLD);
  assign A_OUT     = a_q;
  assign B_OUT     = b_q;
  assign GT_OUT    = gt_q;
  assign ERR       = err_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      s_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (in_fire) begin
          if (IN_FIRST) begin
            s_q     <= IN_DATA;
            state_q <= WAIT_DIFF;
          end else err_q <= 1'b1;
        end
        WAIT_DIFF: if (in_fire) begin
          if (IN_FIRST) begin
            s_q   <= IN_DATA;
            err_q <= 1'b1;
          end else if (s_q[0] != IN_DATA[0]) begin
            // S and D of a genuine pair always share their LSB (both equal A^B bit 0).
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            gt_q    <= gt_d;
            state_q <= HOLD;
          end
        end
        HOLD: if (OUT_READY) begin
          state_q <= IDLE;
          if (IN_VALID) begin
            if (IN_FIRST) begin
              s_q     <= IN_DATA;
              state_q <= WAIT_DIFF;
            end else err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sum_diff_decoder.md
# sum_diff_decoder

Streaming decoder for the sum/difference encoding produced by the edge-triggered adder/subtractor stage. It accepts a two-beat stream and reconstructs the original operand pair (A, B) together with the A > B comparison flag:
- beat 1: S = A + B, unsigned, full width.
- beat 2: D = A - B, two's complement, full width.

It sits on the receive side of that link and presents recovered operands to downstream logic through a valid/ready handshake.

## Interface
Parameters:
- NBITS, 8, operand width; encoded words are NBITS+1 bits wide.

Ports:
- CLK  in  1  clock; all state updates on posedge CLK.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  decoder can accept a beat this cycle.
- IN_FIRST  in  1  marks the sum beat (beat 1 of a pair).
- IN_DATA  in  NBITS+1  encoded word (S on first beat, D on second).
- OUT_VALID  out  1  recovered pair valid.
- OUT_READY  in  1  downstream accepts the pair.
- A_OUT  out  NBITS  recovered A.
- B_OUT  out  NBITS  recovered B.
- GT_OUT  out  1  1 when A_OUT > B_OUT (unsigned).
- ERR  out  1  one-cycle pulse on a protocol or parity error.

## Operation
- Transfer rules:
  - An input beat transfers when IN_VALID && IN_READY.
  - An output transfers when OUT_VALID && OUT_READY.
- States:
  - IDLE: waiting for a sum beat.
  - WAIT_DIFF: S is registered; waiting for D.
  - HOLD: output pair is valid.
- IDLE:
  - Beat with IN_FIRST=1: register S, go to WAIT_DIFF.
  - Beat with IN_FIRST=0: discard it, pulse ERR, stay in IDLE.
- WAIT_DIFF:
  - Beat with IN_FIRST=0: this is D. Check parity:
    - S[0] != D[0] (invalid pair): pulse ERR, drop the pair, go to IDLE.
    - Otherwise: compute the result, go to HOLD.
  - Beat with IN_FIRST=1: resync. Replace S with the new word, pulse ERR, stay in WAIT_DIFF.
- HOLD:
  - OUT_VALID=1. A_OUT, B_OUT and GT_OUT are stable until the output transfers.
  - Output transfers with no input beat: go to IDLE.
  - Output transfers together with a beat with IN_FIRST=1: register the new S, go to WAIT_DIFF.
  - Output transfers together with a beat with IN_FIRST=0: discard the beat, pulse ERR, go to IDLE.
- Arithmetic:
  - Sign-extend D and zero-extend S to NBITS+2 bits.
  - A = (S + D) >> 1, truncated to NBITS.
  - B = (S - D) >> 1, truncated to NBITS.
  - GT = D is positive and non-zero (D[NBITS]==0 && D != 0).
  - All arithmetic is modulo 2^(NBITS+2). The result is exact for any S/D pair produced from valid NBITS-bit operands.
- IN_READY = (state != HOLD) || OUT_READY. This is combinational from state and OUT_READY; there is no combinational path from IN_VALID.

## Timing
- Reset (RST=1 at a posedge) gives, on the next cycle:
  - state=IDLE, OUT_VALID=0, ERR=0.
  - A_OUT=0, B_OUT=0, GT_OUT=0.
  - IN_READY=1.
- Reset overrides every other event in the same cycle. A pair in progress or a held output is discarded, with no ERR pulse.
- Latency: OUT_VALID rises the cycle after the D beat transfers. A_OUT, B_OUT, GT_OUT and ERR are registered.
- Throughput: one pair per 2 cycles when IN_VALID and OUT_READY are held high. In HOLD the next S is accepted in the same cycle the output is consumed.
- ERR is high for exactly one cycle, the cycle after the offending beat transfers. It never coincides with a new OUT_VALID rise for the same pair.
- Backpressure: with OUT_READY=0 in HOLD, IN_READY=0 and the outputs hold their values indefinitely.

## Test plan
- Reset, then feed S=0x12C (IN_FIRST=1) followed by D=0x064, with OUT_READY=1 -> one cycle after D, OUT_VALID=1, A_OUT=200, B_OUT=100, GT_OUT=1, ERR=0.
- Feed S=0x00E followed by D=0x1FC (-4) -> A_OUT=5, B_OUT=9, GT_OUT=0. Then feed S=0x1FE, D=0x000 -> A_OUT=255, B_OUT=255, GT_OUT=0.
- Backpressure: hold OUT_READY=0 after the pair (200,100) completes, with IN_VALID=1 carrying S=0x00A -> IN_READY=0 and outputs stable for 5 cycles. Raise OUT_READY -> the pair transfers and S=0x00A is accepted in the same cycle.
- Errors, each checked as a one-cycle ERR pulse:
  - Parity error: S=0x003 then D=0x002 -> ERR pulse, no OUT_VALID, state IDLE.
  - Resync: S=0x010, then S=0x00C (IN_FIRST=1), then D=0x002 -> ERR pulse on the resync, then A_OUT=7, B_OUT=5.
  - Orphan: a D beat with IN_FIRST=0 in IDLE -> ERR pulse, beat discarded.
- Reset mid-operation: assert RST in WAIT_DIFF and again in HOLD -> next cycle OUT_VALID=0, outputs 0, ERR=0. The following pair decodes correctly.
- Streaming: 100 random valid (A,B) pairs, with random IN_VALID gaps and random OUT_READY stalls -> every output matches its input pair in order, with no drops, duplicates or ERR pulses.
